// File: rtl/mac_seq_feeder_if.sv
// ============================================================================
// Module   : mac_seq_feeder_if
// Purpose  : host-side write/start/status bundle of the MAC sequence feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mac_seq_feeder_if #(
    parameter int AW = 4
);
    logic               wr_en;
    logic signed [3:0]  wr_in;
    logic signed [3:0]  wr_w;
    logic               start;
    logic [AW:0]        count;
    logic               full;
    logic               busy;
    logic               ovf;
    logic signed [11:0] result;
    logic               done;

    modport master (
        output wr_en, wr_in, wr_w, start,
        input  count, full, busy, ovf, result, done
    );

    modport slave (
        input  wr_en, wr_in, wr_w, start,
        output count, full, busy, ovf, result, done
    );
endinterface

`default_nettype wire

// File: rtl/mac_seq_feeder.sv
// ============================================================================
// Module   : mac_seq_feeder
// Purpose  : buffers operand pairs and sequences one clear/stream/drain MAC run.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_seq_feeder #(
    parameter int DEPTH   = 16,
    parameter int MAC_LAT = 1,
    parameter int AW      = 4
) (
    input  wire                clk,
    input  wire                rstb,
    mac_seq_feeder_if.slave    host,
    output logic signed [3:0]  mac_in,
    output logic signed [3:0]  mac_w,
    output logic               mac_rstb,
    input  wire signed [11:0]  mac_out
);
    localparam int          c_DRW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [AW:0] c_FULL       = (AW+1)'(DEPTH);
    localparam logic [c_DRW-1:0] c_DRAIN_LAST = c_DRW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_buf [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      w_rd_addr;
    logic [AW:0]        r_count;
    logic [AW:0]        w_count_nxt;
    logic [c_DRW-1:0]   r_drain;
    logic               r_full;
    logic               r_busy;
    logic               r_ovf;
    logic               r_done;
    logic signed [11:0] r_result;
    logic signed [3:0]  r_mac_in;
    logic signed [3:0]  r_mac_w;
    logic               r_mac_rstb;
    logic               w_wr_ok;
    logic               w_last;

    assign w_wr_ok = (r_state == S_IDLE) && host.wr_en && !r_full;
    assign w_last  = ({1'b0, r_rd_ptr} == (r_count - 1'b1));
    // Operands are registered, so the next pair is fetched one cycle ahead.
    assign w_rd_addr = (r_state == S_CLEAR) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (host.start) w_state_nxt = S_CLEAR;
            S_CLEAR:  w_state_nxt = (r_count != '0) ? S_STREAM : S_DRAIN;
            S_STREAM: if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_drain == c_DRAIN_LAST) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (r_state == S_DONE) begin
            w_count_nxt = '0;
        end else if (w_wr_ok) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_buf[r_wr_ptr] <= {host.wr_in, host.wr_w};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drain    <= '0;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_mac_in   <= '0;
            r_mac_w    <= '0;
            r_mac_rstb <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == c_FULL);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_mac_rstb <= (w_state_nxt != S_CLEAR);
            r_done     <= (r_state == S_DONE);

            if (host.wr_en && (r_full || (r_state != S_IDLE))) begin
                r_ovf <= 1'b1;
            end

            if (r_state == S_DONE) begin
                r_wr_ptr <= '0;
                r_result <= mac_out;
            end else if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (r_state == S_STREAM) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
                r_rd_ptr <= '0;
            end

            r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;

            // Zero operands outside STREAM keep the MAC accumulator frozen.
            if (w_state_nxt == S_STREAM) begin
                r_mac_in <= r_buf[w_rd_addr][7:4];
                r_mac_w  <= r_buf[w_rd_addr][3:0];
            end else begin
                r_mac_in <= '0;
                r_mac_w  <= '0;
            end
        end
    end

    assign host.count  = r_count;
    assign host.full   = r_full;
    assign host.busy   = r_busy;
    assign host.ovf    = r_ovf;
    assign host.result = r_result;
    assign host.done   = r_done;
    assign mac_in      = r_mac_in;
    assign mac_w       = r_mac_w;
    assign mac_rstb    = r_mac_rstb;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_feeder.sv
// ============================================================================
// Module   : tb_mac_seq_feeder
// Purpose  : bench for mac_seq_feeder with a behavioural MAC and run model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mac_seq_feeder;
    localparam int DEPTH   = 16;
    localparam int MAC_LAT = 1;
    localparam int AW      = 4;

    logic               clk  = 1'b0;
    logic               rstb = 1'b0;
    logic signed [3:0]  mac_in;
    logic signed [3:0]  mac_w;
    logic               mac_rstb;
    logic signed [11:0] mac_out;
    logic signed [11:0] acc;
    logic signed [7:0]  prod;

    mac_seq_feeder_if #(.AW(AW)) h();

    mac_seq_feeder #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT), .AW(AW)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .host     (h),
        .mac_in   (mac_in),
        .mac_w    (mac_w),
        .mac_rstb (mac_rstb),
        .mac_out  (mac_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the external MAC: one-cycle accumulate, async clear.
    assign prod = mac_in * mac_w;
    always_ff @(posedge clk or negedge mac_rstb) begin
        if (!mac_rstb) acc <= '0;
        else           acc <= acc + {{4{prod[7]}}, prod};
    end
    assign mac_out = acc;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    endtask

    function automatic int sx4(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    function automatic int wrap12(input int v);
        logic signed [11:0] r;
        r = v[11:0];
        return int'(r);
    endfunction

    // Reference model: a queue of buffered pairs plus a run timeline derived
    // from the start edge (clear, cnt stream cycles, drain, done).
    logic [7:0] mq[$];
    bit running  = 0;
    int rs       = 0;
    int rcnt     = 0;
    int exp_sum  = 0;
    bit e_ovf    = 0;
    bit e_done   = 0;
    bit e_mrstb  = 0;
    int e_result = 0;
    int e_min    = 0;
    int e_mw     = 0;

    initial begin
        forever begin
            int t;
            @(posedge clk);
            cyc++;
            e_done = 0;
            e_min  = 0;
            e_mw   = 0;
            if (!rstb) begin
                mq.delete();
                running  = 0;
                e_ovf    = 0;
                e_result = 0;
                e_mrstb  = 0;
            end else begin
                e_mrstb = 1;
                if (!running) begin
                    if (h.wr_en) begin
                        if (mq.size() < DEPTH) mq.push_back({h.wr_in, h.wr_w});
                        else e_ovf = 1;
                    end
                    if (h.start) begin
                        running = 1;
                        rs      = cyc;
                        rcnt    = mq.size();
                        e_mrstb = 0;
                        exp_sum = 0;
                        foreach (mq[i]) exp_sum += sx4(mq[i][7:4]) * sx4(mq[i][3:0]);
                    end
                end else begin
                    if (h.wr_en) e_ovf = 1;
                    t = cyc - rs;
                    if (t >= 1 && t <= rcnt) begin
                        e_min = sx4(mq[t-1][7:4]);
                        e_mw  = sx4(mq[t-1][3:0]);
                    end
                    if (t == rcnt + 2 + MAC_LAT) begin
                        running  = 0;
                        e_done   = 1;
                        e_result = wrap12(exp_sum);
                        mq.delete();
                    end
                end
            end
            #1;
            chk("count",    int'(h.count), mq.size());
            chk("full",     int'(h.full), int'(mq.size() == DEPTH));
            chk("busy",     int'(h.busy), int'(running));
            chk("ovf",      int'(h.ovf), int'(e_ovf));
            chk("done",     int'(h.done), int'(e_done));
            chk("result",   int'(h.result), e_result);
            chk("mac_rstb", int'(mac_rstb), int'(e_mrstb));
            chk("mac_in",   int'(mac_in), e_min);
            chk("mac_w",    int'(mac_w), e_mw);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        h.wr_en = 1'b1;
        h.wr_in = a;
        h.wr_w  = b;
        @(negedge clk);
        h.wr_en = 1'b0;
    endtask

    task automatic run_check(input bit wr_same, input logic [3:0] a, input logic [3:0] b,
                             input bit wr_during, input int exp_lat, input int exp_res,
                             input string nm);
        int n;
        int lows;
        bit seen;
        n    = 0;
        lows = 0;
        seen = 0;
        @(negedge clk);
        h.start = 1'b1;
        if (wr_same) begin
            h.wr_en = 1'b1;
            h.wr_in = a;
            h.wr_w  = b;
        end
        @(negedge clk);
        chk({nm, "_clear_rstb"}, int'(mac_rstb), 0);
        h.start = 1'b0;
        h.wr_en = wr_during;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            h.wr_en = 1'b0;
            n = i;
            if (!mac_rstb) lows++;
            if (h.done) seen = 1;
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_result"}, int'(h.result), exp_res);
        chk({nm, "_count"}, int'(h.count), 0);
        chk({nm, "_extra_rstb"}, lows, 0);
    endtask

    initial begin
        logic [7:0] t1 [0:8];
        logic [7:0] t2 [0:10];
        bit seen_done;
        t1 = '{8'h43, 8'hF2, 8'h2E, 8'h11, 8'hD1, 8'h3F, 8'hE2, 8'h2D, 8'hCC};
        t2 = '{8'h11, 8'hFF, 8'h22, 8'hEE, 8'h33, 8'hDD, 8'h44, 8'hCC, 8'h1F, 8'hF1, 8'h2E};
        h.wr_en = 1'b0;
        h.wr_in = '0;
        h.wr_w  = '0;
        h.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(h.count), 0);
        chk("rst_busy", int'(h.busy), 0);
        chk("rst_mac_rstb", int'(mac_rstb), 0);
        chk("rst_result", int'(h.result), 0);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_mac_rstb", int'(mac_rstb), 1);

        foreach (t1[i]) wr(t1[i][7:4], t1[i][3:0]);
        chk("load9_count", int'(h.count), 9);
        run_check(0, 4'd0, 4'd0, 0, 12, 7, "run9");

        foreach (t2[i]) wr(t2[i][7:4], t2[i][3:0]);
        run_check(0, 4'd0, 4'd0, 0, 14, 54, "run11");

        for (int i = 0; i < 17; i++) wr(4'h8, 4'h8);
        chk("fill_full", int'(h.full), 1);
        chk("fill_ovf", int'(h.ovf), 1);
        chk("fill_count", int'(h.count), 16);
        run_check(0, 4'd0, 4'd0, 0, 19, 1024, "run16");

        // Reset asserted while the fifth pair is on the MAC inputs.
        foreach (t1[i]) wr(t1[i][7:4], t1[i][3:0]);
        @(negedge clk);
        h.start = 1'b1;
        @(negedge clk);
        h.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_before", int'(h.busy), 1);
        chk("mid_mac_in_k4", int'(mac_in), -3);
        rstb = 1'b0;
        #1;
        chk("mid_busy", int'(h.busy), 0);
        chk("mid_count", int'(h.count), 0);
        chk("mid_result", int'(h.result), 0);
        chk("mid_mac_rstb", int'(mac_rstb), 0);
        chk("mid_ovf", int'(h.ovf), 0);
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (h.done) seen_done = 1;
        end
        @(negedge clk);
        rstb = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (h.done) seen_done = 1;
        end
        chk("mid_no_done", int'(seen_done), 0);

        run_check(0, 4'd0, 4'd0, 1, 3, 0, "empty");
        chk("empty_ovf", int'(h.ovf), 1);

        wr(4'd1, 4'd2);
        wr(4'hF, 4'd1);
        run_check(1, 4'd3, 4'd2, 0, 6, 7, "same");

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rstb    = ($urandom_range(0, 249) != 0);
            h.wr_en = ($urandom_range(0, 99) < 45);
            h.wr_in = 4'($urandom);
            h.wr_w  = 4'($urandom);
            h.start = ($urandom_range(0, 99) < ((i < 750) ? 4 : 1));
        end
        @(negedge clk);
        rstb    = 1'b1;
        h.wr_en = 1'b0;
        h.start = 1'b0;
        repeat (40) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
